// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for the Sobel Gx/Gy stages. Two line buffers hold the
// previous rows; a registered window and a one-cycle strobe are issued per interior pixel.
module sobel_window_gen #(
  parameter int data_size  = 24,
  parameter int img_width  = 640,
  parameter int img_height = 480
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pixel_valid,
  input  logic                 sof,
  input  logic [data_size-1:0] pixel_in,
  output logic                 window_valid,
  output logic [data_size-1:0] w00,
  output logic [data_size-1:0] w01,
  output logic [data_size-1:0] w02,
  output logic [data_size-1:0] w10,
  output logic [data_size-1:0] w11,
  output logic [data_size-1:0] w12,
  output logic [data_size-1:0] w20,
  output logic [data_size-1:0] w21,
  output logic [data_size-1:0] w22,
  output logic                 frame_done
);

  localparam int CW = (img_width  > 1) ? $clog2(img_width)  : 1;
  localparam int RW = (img_height > 1) ? $clog2(img_height) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(img_width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(img_height - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]        col_q, col_d, pos_col_s;
  logic [RW-1:0]        row_q, row_d, pos_row_s;
  logic [data_size-1:0] lb_old_q [img_width];
  logic [data_size-1:0] lb_new_q [img_width];
  logic [data_size-1:0] old_rd_s, new_rd_s;
  logic [data_size-1:0] win_q [3][3];
  logic [data_size-1:0] win_d [3][3];
  logic                 window_valid_q, window_valid_d;
  logic                 frame_done_q, frame_done_d;

  // A sof pixel is always position (0,0), whatever the counters say.
  assign pos_col_s = (pixel_valid && sof) ? '0 : col_q;
  assign pos_row_s = (pixel_valid && sof) ? '0 : row_q;

  // Pre-write contents feed the window (read-before-write at the same address).
  assign old_rd_s = lb_old_q[pos_col_s];
  assign new_rd_s = lb_new_q[pos_col_s];

  // Next-state: window shift, position advance and output strobes.
  always_comb begin
    col_d          = col_q;
    row_d          = row_q;
    win_d          = win_q;
    window_valid_d = 1'b0;
    frame_done_d   = 1'b0;
    if (pixel_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = old_rd_s;
      win_d[1][2] = new_rd_s;
      win_d[2][2] = pixel_in;
      if (pos_col_s == COL_LAST) begin
        col_d = '0;
        if (pos_row_s == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = pos_row_s + RW'(1);
        end
      end else begin
        col_d = pos_col_s + CW'(1);
        row_d = pos_row_s;
      end
      window_valid_d = !sof && (pos_row_s >= ROW_TWO) && (pos_col_s >= COL_TWO);
      frame_done_d   = !sof && (pos_row_s == ROW_LAST) && (pos_col_s == COL_LAST);
    end else begin
      window_valid_d = 1'b0;
      frame_done_d   = 1'b0;
    end
  end

  // Counters, window registers and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q          <= '0;
      row_q          <= '0;
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      window_valid_q <= window_valid_d;
      frame_done_q   <= frame_done_d;
      win_q          <= win_d;
    end
  end

  // Line buffers are plain storage with no reset; the row-2 gate hides stale contents.
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      lb_old_q[pos_col_s] <= new_rd_s;
      lb_new_q[pos_col_s] <= pixel_in;
    end
  end

  assign window_valid = window_valid_q;
  assign frame_done   = frame_done_q;
  assign w00 = win_q[0][0];
  assign w01 = win_q[0][1];
  assign w02 = win_q[0][2];
  assign w10 = win_q[1][0];
  assign w11 = win_q[1][1];
  assign w12 = win_q[1][2];
  assign w20 = win_q[2][0];
  assign w21 = win_q[2][1];
  assign w22 = win_q[2][2];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen: a 4x4 instance driven through the directed
// scenarios and a 3x3 instance at minimum size; monitors pop expected windows on each strobe.
module tb_sobel_window_gen;
  localparam int DS = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_pv, a_sof, a_wv, a_fd;
  logic [DS-1:0] a_pix, a_w00, a_w01, a_w02, a_w10, a_w11, a_w12, a_w20, a_w21, a_w22;
  logic b_pv, b_sof, b_wv, b_fd;
  logic [DS-1:0] b_pix, b_w00, b_w01, b_w02, b_w10, b_w11, b_w12, b_w20, b_w21, b_w22;
  logic [9*DS-1:0] a_win, b_win;

  assign a_win = {a_w00, a_w01, a_w02, a_w10, a_w11, a_w12, a_w20, a_w21, a_w22};
  assign b_win = {b_w00, b_w01, b_w02, b_w10, b_w11, b_w12, b_w20, b_w21, b_w22};

  sobel_window_gen #(.data_size(DS), .img_width(4), .img_height(4)) u_a (
    .clk(clk), .rst(rst), .pixel_valid(a_pv), .sof(a_sof), .pixel_in(a_pix),
    .window_valid(a_wv),
    .w00(a_w00), .w01(a_w01), .w02(a_w02), .w10(a_w10), .w11(a_w11), .w12(a_w12),
    .w20(a_w20), .w21(a_w21), .w22(a_w22), .frame_done(a_fd));

  sobel_window_gen #(.data_size(DS), .img_width(3), .img_height(3)) u_b (
    .clk(clk), .rst(rst), .pixel_valid(b_pv), .sof(b_sof), .pixel_in(b_pix),
    .window_valid(b_wv),
    .w00(b_w00), .w01(b_w01), .w02(b_w02), .w10(b_w10), .w11(b_w11), .w12(b_w12),
    .w20(b_w20), .w21(b_w21), .w22(b_w22), .frame_done(b_fd));

  typedef struct packed {
    logic [31:0]     stamp;
    logic            fd;
    logic [9*DS-1:0] w;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   mr = 0;
  int   mc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check_item(input string nm, input exp_t e, input int c,
                                     input logic wv, input logic fd, input logic [9*DS-1:0] win);
    vectors++;
    if (c != int'(e.stamp) || wv !== 1'b1 || fd !== e.fd || win !== e.w) begin
      miscompares++;
      $display("FAIL %s: got cycle %0d wv=%b fd=%b win=%h, required cycle %0d wv=1 fd=%b win=%h",
               nm, c, wv, fd, win, e.stamp, e.fd, e.w);
    end
  endfunction

  // Monitor for the 4x4 instance.
  always @(negedge clk) begin
    if (rst === 1'b0 && (a_wv === 1'b1 || a_fd === 1'b1)) begin
      if (qa.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL a_unexpected_strobe: got wv=%b fd=%b at cycle %0d, required no strobe",
                 a_wv, a_fd, cyc);
      end else begin
        check_item("a_window", qa.pop_front(), cyc, a_wv, a_fd, a_win);
      end
    end
  end

  // Monitor for the 3x3 instance.
  always @(negedge clk) begin
    if (rst === 1'b0 && (b_wv === 1'b1 || b_fd === 1'b1)) begin
      if (qb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL b_unexpected_strobe: got wv=%b fd=%b at cycle %0d, required no strobe",
                 b_wv, b_fd, cyc);
      end else begin
        check_item("b_window", qb.pop_front(), cyc, b_wv, b_fd, b_win);
      end
    end
  end

  // Pixel value for 4x4 frames is base + 4*row + col; expected windows follow from that.
  task automatic a_send(input int base, input bit s);
    exp_t e;
    e = '0;
    @(negedge clk);
    if (s) begin
      mr = 0;
      mc = 0;
    end
    a_pv  = 1'b1;
    a_sof = s;
    a_pix = DS'(base + 4 * mr + mc);
    if (mr >= 2 && mc >= 2) begin
      e.stamp = 32'(cyc + 1);
      e.fd    = (mr == 3 && mc == 3);
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          e.w[(8 - (3 * i + j)) * DS +: DS] = DS'(base + 4 * (mr - 2 + i) + (mc - 2 + j));
        end
      end
      qa.push_back(e);
    end
    mc++;
    if (mc == 4) begin
      mc = 0;
      mr = (mr == 3) ? 0 : mr + 1;
    end
  endtask

  task automatic a_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      a_pv  = 1'b0;
      a_sof = 1'b0;
    end
  endtask

  task automatic a_frame(input int base, input bit first_sof, input int gap);
    for (int k = 0; k < 16; k++) begin
      a_send(base, first_sof && (k == 0));
      if (gap > 0) a_idle(gap);
    end
  endtask

  task automatic check_zero(input string nm, input logic wv, input logic fd,
                            input logic [9*DS-1:0] win);
    vectors++;
    if (wv !== 1'b0 || fd !== 1'b0 || win !== '0) begin
      miscompares++;
      $display("FAIL %s: got wv=%b fd=%b win=%h, required all zero", nm, wv, fd, win);
    end
  endtask

  initial begin
    exp_t eb;
    rst = 1'b1;
    a_pv = 1'b0; a_sof = 1'b0; a_pix = '0;
    b_pv = 1'b0; b_sof = 1'b0; b_pix = '0;
    repeat (3) @(negedge clk);
    check_zero("a_reset_state", a_wv, a_fd, a_win);
    check_zero("b_reset_state", b_wv, b_fd, b_win);
    rst = 1'b0;

    // Continuous frame with sof, then the same stream with 3-cycle gaps after natural wrap.
    a_frame(0, 1'b1, 0);
    a_frame(0, 1'b0, 3);
    // Back-to-back frames: one opened by sof, the next by counter wrap.
    a_frame(100, 1'b1, 0);
    a_frame(200, 1'b0, 0);
    // Partial frame through (2,0); sof lands where (2,1) would have been.
    for (int k = 0; k < 9; k++) a_send(300, k == 0);
    a_frame(400, 1'b1, 0);
    // Partial frame through (2,1), then an asynchronous reset between clock edges.
    for (int k = 0; k < 10; k++) a_send(500, k == 0);
    @(negedge clk);
    a_pv = 1'b0;
    a_sof = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero("a_async_reset", a_wv, a_fd, a_win);
    mr = 0;
    mc = 0;
    @(negedge clk);
    rst = 1'b0;
    a_frame(600, 1'b0, 0);
    a_idle(2);

    // Minimum-size frame: values 1..9, a single window together with frame_done.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      b_pv  = 1'b1;
      b_sof = (k == 0);
      b_pix = DS'(k + 1);
      if (k == 8) begin
        eb.stamp = 32'(cyc + 1);
        eb.fd    = 1'b1;
        eb.w     = {24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 24'd6, 24'd7, 24'd8, 24'd9};
        qb.push_back(eb);
      end
    end
    @(negedge clk);
    b_pv  = 1'b0;
    b_sof = 1'b0;
    repeat (4) @(negedge clk);

    vectors++;
    if (qa.size() != 0) begin
      miscompares++;
      $display("FAIL a_missing_windows: got %0d expected windows never seen, required 0", qa.size());
    end
    vectors++;
    if (qb.size() != 0) begin
      miscompares++;
      $display("FAIL b_missing_windows: got %0d expected windows never seen, required 0", qb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 window generator that sits directly upstream of the Sobel convolution stage. It accepts one raster-order pixel per valid cycle and buffers the two previous image rows in internal line buffers. For every interior pixel position it presents a registered 3x3 neighbourhood with a one-cycle valid strobe. The Gx and Gy convolution instances take their six taps each from this window.

## Interface
- `data_size`, 24, pixel width in bits (unsigned).
- `img_width`, 640, pixels per row; must be at least 3.
- `img_height`, 480, rows per frame; must be at least 3.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `pixel_valid`  in  1  `pixel_in` is accepted this cycle.
- `sof`  in  1  start of frame; meaningful only when `pixel_valid` is high.
- `pixel_in`  in  `data_size`  raster-order pixel.
- `window_valid`  out  1  window outputs are valid this cycle (single-cycle strobe per window).
- `w00`..`w22`  out  `data_size` each, 9 ports  window pixel at row `r`, column `c`. Row 0 is the oldest row. Column 0 is the leftmost (oldest) column.
- `frame_done`  out  1  single-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Internal position counters `col` (0..`img_width`-1) and `row` (0..`img_height`-1) give the position of the next accepted pixel. Both reset to 0.
- Two line buffers, `lb_old` and `lb_new`, each hold `img_width` × `data_size` bits and are addressed by `col`. Buffer contents are not reset.
- Accepting a pixel (`pixel_valid`=1) at position (`row`,`col`) does the following in one cycle:
  - read `lb_old[col]` (row `row`-2) and `lb_new[col]` (row `row`-1);
  - shift the window left by one column: w*0 ← w*1 and w*1 ← w*2;
  - load w02 ← `lb_old[col]`, w12 ← `lb_new[col]`, w22 ← `pixel_in`;
  - write `lb_old[col]` ← `lb_new[col]` and `lb_new[col]` ← `pixel_in`;
  - advance `col`. At `img_width`-1, `col` wraps to 0 and `row` increments. At `row` = `img_height`-1 with that wrap, `row` also wraps to 0.
- `window_valid` is registered high for one cycle when the accepted pixel had `row`≥2 and `col`≥2. Otherwise it is registered low.
- There is no border padding. Each frame yields exactly (`img_width`-2)×(`img_height`-2) windows.
- `frame_done` is registered high for one cycle when the accepted pixel is at (`img_height`-1, `img_width`-1).
- `sof` with `pixel_valid` forces the accepted pixel to position (0,0). After it, `col`=1 and `row`=0, regardless of the previous counter state.
  - Any partial frame is abandoned. No `window_valid` and no `frame_done` are produced for the sof pixel.
  - `sof` without `pixel_valid` is ignored.
- `pixel_valid` low is a stall:
  - counters, window registers and buffers hold;
  - `window_valid` and `frame_done` drive 0.
- Tap mapping into the convolution stage:
  - Gx: p1a=w02, p2=w12, p1b=w22; m1a=w00, m2=w10, m1b=w20.
  - Gy: p1a=w20, p2=w21, p1b=w22; m1a=w00, m2=w01, m1b=w02.

## Timing
- Reset (asynchronous assert, synchronous release at the next `clk` edge):
  - all nine window outputs are 0;
  - `window_valid`=0 and `frame_done`=0;
  - `col`=0 and `row`=0.
- Reset mid-frame discards the frame. The next accepted pixel is treated as (0,0) even without `sof`.
- Latency: the window outputs and `window_valid` update on the clock edge that accepts the pixel completing the window, so they are visible one cycle after that pixel is presented.
- Throughput is one pixel per cycle with no back-pressure; the block never stalls the source.
- Window outputs hold their last value while `window_valid` is low. Consumers sample only on `window_valid`.
- Row wrap and frame wrap occur in the same cycle as the last pixel's acceptance. A pixel in the next cycle is accepted as (0,0) or (row+1,0) with no bubble.
- Line buffers use read-before-write at the same address: the pre-write value is the one loaded into the window.

## Test plan
- W=4, H=4, continuous valid, pixel value = 4·r+c, `sof` on the first pixel:
  - the first `window_valid` comes one cycle after pixel 10 (position (2,2)), with w00..w22 = 0,1,2 / 4,5,6 / 8,9,10;
  - exactly 4 windows per frame, the last one being 5,6,7 / 9,10,11 / 13,14,15;
  - `frame_done` is high in the same cycle as that last window.
- Same stream with `pixel_valid` low for 3 cycles after every accepted pixel: window contents, count and order are identical to the first scenario; `window_valid` never asserts during a gap.
- Two back-to-back frames with no idle cycle between them:
  - the second frame's first window appears one cycle after its pixel (2,2), not earlier;
  - no window mixes rows from the two frames.
- `sof` asserted at frame position (2,1): counters resync; the next valid window is one cycle after the new frame's pixel (2,2); no `frame_done` for the aborted frame.
- `rst` pulsed asynchronously in the middle of row 2:
  - all outputs read 0 immediately;
  - the restarted frame, sent without `sof`, produces its first window at its pixel (2,2) with correct values.
- W=3, H=3 at minimum size, values 1..9: exactly one window, 1,2,3 / 4,5,6 / 7,8,9, with `window_valid` and `frame_done` high together.
